// File: rtl/spi_pkg.sv
// Shared SPI definitions: receiver state encoding, mode helper and the default word width
// common to both ends of the link.
package spi_pkg;

    typedef enum logic {
        StIdle   = 1'b0,
        StActive = 1'b1
    } rx_state_e;

    localparam int unsigned SPI_DATA_BITS = 8;

    // Data is captured on the rising SCLK edge when CPOL and CPHA agree.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return (cpol == cpha);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with rise/fall pulses derived from the
// synchronised level and its one-cycle delay.
module spi_sync_edge #(
    parameter logic        RST_VAL = 1'b0,
    parameter int unsigned STAGES  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_q;
    logic              level_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RST_VAL}};
            level_q <= RST_VAL;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], din};
            level_q <= chain_q[STAGES-1];
        end
    end

    assign level = chain_q[STAGES-1];
    assign rise  = level & ~level_q;
    assign fall  = ~level & level_q;

endmodule

// File: rtl/spi_s_rx.sv
// SPI slave receiver: oversamples SCLK, CS_n and MOSI in the i_clk domain and assembles
// MSB-first words, strobing each completed word and flagging frames cut short by CS.
module spi_s_rx
    import spi_pkg::*;
#(
    parameter logic        CPOL        = 1'b1,
    parameter logic        CPHA        = 1'b0,
    parameter int unsigned DATA_BITS   = SPI_DATA_BITS,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_spi_clk,
    input  logic                 i_spi_cs_n,
    input  logic                 i_spi_rx,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_data_valid,
    output logic                 o_spi_busy,
    output logic                 o_frame_err
);

    localparam int unsigned CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic sample_edge;
    logic unused_sync;

    spi_sync_edge #(
        .RST_VAL (CPOL),
        .STAGES  (SYNC_STAGES)
    ) u_sclk_sync (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .din   (i_spi_clk),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(
        .RST_VAL (1'b1),
        .STAGES  (SYNC_STAGES)
    ) u_cs_sync (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .din   (i_spi_cs_n),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    assign unused_sync = ^{sclk_level, cs_level};

    // Same depth as the SCLK chain so the data bit lines up with its sampling edge.
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   mosi_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mosi_q <= '0;
        end else begin
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], i_spi_rx};
        end
    end

    assign mosi_sync   = mosi_q[SYNC_STAGES-1];
    assign sample_edge = sample_on_rise(CPOL, CPHA) ? sclk_rise : sclk_fall;

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] sr_q, sr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d   = StActive;
                    bit_cnt_d = '0;
                end
            end
            StActive: begin
                // CS release wins over a coincident sample edge.
                if (cs_rise) begin
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                    err_d     = (bit_cnt_q != '0);
                end else if (sample_edge) begin
                    sr_d = {sr_q[DATA_BITS-2:0], mosi_sync};
                    if (bit_cnt_q == LAST_BIT) begin
                        data_d    = sr_d;
                        valid_d   = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign o_rx_data       = data_q;
    assign o_rx_data_valid = valid_q;
    assign o_spi_busy      = (state_q == StActive);
    assign o_frame_err     = err_q;

endmodule
